// File: rtl/fp_pkg.sv
// Shared single-precision constants, field widths and the divider state encoding.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 24;
    localparam int REM_W  = 26;
    localparam int QUO_W  = 25;
    localparam int CNT_W  = 5;
    localparam int E_W    = 10;

    localparam int                BIAS    = 127;
    localparam logic [EXP_W-1:0]  EXP_INF = 8'hFF;
    localparam logic [31:0]       QNAN    = 32'h7FC00000;
    localparam logic [31:0]       PINF    = 32'h7F800000;
    localparam logic [CNT_W-1:0]  LAST_ITER = 5'd24;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;
endpackage

// File: rtl/exponent_sub.sv
// Quotient exponent: ea - eb + bias - dec, wide and signed so overflow/underflow stay visible.
module exponent_sub
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0]        ea_i,
    input  logic [EXP_W-1:0]        eb_i,
    input  logic                    dec_i,
    output logic signed [E_W-1:0]   e_o
);
    localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);

    logic signed [E_W-1:0] ea_s;
    logic signed [E_W-1:0] eb_s;
    logic signed [E_W-1:0] dec_s;

    assign ea_s  = $signed({2'b00, ea_i});
    assign eb_s  = $signed({2'b00, eb_i});
    assign dec_s = $signed({{(E_W-1){1'b0}}, dec_i});
    assign e_o   = ea_s - eb_s + BIAS_S - dec_s;
endmodule

// File: rtl/fp_divide_iter.sv
// Iterative single-precision divider: restoring 1-bit/cycle mantissa divide, truncating,
// with start/busy/done handshake and registered result and exception flags.
module fp_divide_iter
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [REM_W-1:0]      dvs_q, dvs_d;
    logic [QUO_W-1:0]      quo_q, quo_d;
    logic [EXP_W-1:0]      ea_q, ea_d, eb_q, eb_d;
    logic                  sign_q, sign_d;
    logic [31:0]           result_q, result_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, dz_q, dz_d, inv_q, inv_d;

    logic                  a_zero, b_zero, a_nf, b_nf, is_inv, special, sgn;
    logic                  ge;
    logic                  dec;
    logic [FRAC_W-1:0]     frac;
    logic signed [E_W-1:0] e_w;

    assign a_zero  = (a[30:23] == '0);
    assign b_zero  = (b[30:23] == '0);
    assign a_nf    = (a[30:23] == EXP_INF);
    assign b_nf    = (b[30:23] == EXP_INF);
    assign is_inv  = (a_zero && b_zero) || a_nf || b_nf;
    assign special = is_inv || b_zero || a_zero;
    assign sgn     = a[31] ^ b[31];

    assign ge   = (rem_q >= dvs_q);
    assign dec  = ~quo_q[QUO_W-1];
    assign frac = quo_q[QUO_W-1] ? quo_q[QUO_W-2:1] : quo_q[QUO_W-3:0];

    exponent_sub u_exp (
        .ea_i  (ea_q),
        .eb_i  (eb_q),
        .dec_i (dec),
        .e_o   (e_w)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dz_d     = dz_q;
        inv_d    = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    dz_d   = 1'b0;
                    inv_d  = 1'b0;
                    sign_d = sgn;
                    ea_d   = a[30:23];
                    eb_d   = b[30:23];
                    if (special) begin
                        state_d = DONE;
                        if (is_inv) begin
                            result_d = QNAN;
                            inv_d    = 1'b1;
                        end else if (b_zero) begin
                            result_d = {sgn, PINF[30:0]};
                            dz_d     = 1'b1;
                        end else begin
                            result_d = {sgn, 31'd0};
                        end
                    end else begin
                        state_d = DIV;
                        rem_d   = {2'b01, a[22:0]};
                        dvs_d   = {2'b01, b[22:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            DIV: begin
                // Restoring step: quotient bits enter at the LSB so the first lands at q[24].
                rem_d = ge ? ((rem_q - dvs_q) << 1) : (rem_q << 1);
                quo_d = {quo_q[QUO_W-2:0], ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                if (e_w >= 10'sd255) begin
                    result_d = {sign_q, EXP_INF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (e_w <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, e_w[EXP_W-1:0], frac};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dz_q     <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dz_q     <= dz_d;
            inv_q    <= inv_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded before use.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        dvs_q  <= dvs_d;
        quo_q  <= quo_d;
        ea_q   <= ea_d;
        eb_q   <= eb_d;
        sign_q <= sign_d;
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign div_by_zero = dz_q;
    assign invalid     = inv_q;
endmodule
